// File: rtl/vball_pal_arbiter_pkg.sv
// Shared types and widths for the palette RAM arbiter.
// Slot tags, palette geometry and the CPU lane-select bit position.
package vball_pal_arbiter_pkg;

  localparam int unsigned PAL_AW = 10;
  localparam int unsigned PAL_DW = 12;
  localparam int unsigned CPU_AW = PAL_AW + 1;
  localparam int unsigned CPU_DW = 8;
  localparam int unsigned WAIT_W = 4;

  // Bit of cpu_addr that selects the blue-nibble lane.
  localparam int unsigned LANE_B = 10;

  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_BG   = 2'd1,
    SLOT_SP   = 2'd2,
    SLOT_CPU  = 2'd3
  } slot_e;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/vball_pal_arbiter_if.sv
// Requester, CPU and palette RAM signals of the arbiter.
// slave is the arbiter side; master is the video engines, CPU and RAM side.
interface vball_pal_arbiter_if;
  import vball_pal_arbiter_pkg::*;

  logic              bg_req;
  logic [PAL_AW-1:0] bg_addr;
  logic              bg_valid;
  logic [PAL_DW-1:0] bg_data;

  logic              sp_req;
  logic [PAL_AW-1:0] sp_addr;
  logic              col_busy;
  logic              sp_valid;
  logic [PAL_DW-1:0] sp_data;

  logic              cpu_we;
  logic [CPU_AW-1:0] cpu_addr;
  logic [CPU_DW-1:0] cpu_din;
  logic              cpu_busy;

  logic [PAL_AW-1:0] ram_addr;
  logic              ram_we_rg;
  logic              ram_we_b;
  logic [PAL_DW-1:0] ram_d;
  logic [PAL_DW-1:0] ram_q;

  modport slave (
    input  bg_req, bg_addr, sp_req, sp_addr, cpu_we, cpu_addr, cpu_din, ram_q,
    output bg_valid, bg_data, col_busy, sp_valid, sp_data, cpu_busy,
    output ram_addr, ram_we_rg, ram_we_b, ram_d
  );

  modport master (
    output bg_req, bg_addr, sp_req, sp_addr, cpu_we, cpu_addr, cpu_din, ram_q,
    input  bg_valid, bg_data, col_busy, sp_valid, sp_data, cpu_busy,
    input  ram_addr, ram_we_rg, ram_we_b, ram_d
  );

endinterface

// File: rtl/vball_pal_wbuf.sv
// One-entry posted CPU palette write buffer.
// Loads only while empty; the arbiter drains it by granting a CPU slot.
module vball_pal_wbuf
  import vball_pal_arbiter_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [CPU_DW-1:0] cpu_din,
  input  logic              drain,
  output logic              full,
  output logic              lane_b,
  output logic [PAL_AW-1:0] entry,
  output logic [CPU_DW-1:0] data
);

  logic              full_q, full_d;
  logic              lane_b_q, lane_b_d;
  logic [PAL_AW-1:0] entry_q, entry_d;
  logic [CPU_DW-1:0] data_q, data_d;
  logic              load;

  // A write arriving while full (including the drain cycle) is dropped.
  assign load = cpu_we && !full_q;

  always_comb begin
    full_d   = full_q;
    lane_b_d = lane_b_q;
    entry_d  = entry_q;
    data_d   = data_q;
    if (load) begin
      full_d   = 1'b1;
      lane_b_d = cpu_addr[LANE_B];
      entry_d  = cpu_addr[PAL_AW-1:0];
      data_d   = cpu_din;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      full_q   <= 1'b0;
      lane_b_q <= 1'b0;
      entry_q  <= '0;
      data_q   <= '0;
    end else begin
      full_q   <= full_d;
      lane_b_q <= lane_b_d;
      entry_q  <= entry_d;
      data_q   <= data_d;
    end
  end

  assign full   = full_q;
  assign lane_b = lane_b_q;
  assign entry  = entry_q;
  assign data   = data_q;

endmodule

// File: rtl/vball_pal_arbiter.sv
// Single-port palette RAM arbiter: background, sprite and posted CPU writes.
// One slot per cycle; reads return through a two-stage tag pipeline.
module vball_pal_arbiter
  import vball_pal_arbiter_pkg::*;
#(
  parameter int unsigned SP_MAXWAIT = 6
) (
  input logic clk_sys,
  input logic reset,
  vball_pal_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] SpMaxWait =
    (SP_MAXWAIT > 15) ? 4'd15 : WAIT_W'(SP_MAXWAIT);

  slot_e             slot;
  logic              sp_starved;
  logic              col_busy;

  logic              wb_full;
  logic              wb_lane_b;
  logic [PAL_AW-1:0] wb_entry;
  logic [CPU_DW-1:0] wb_data;

  logic [WAIT_W-1:0] sp_wait_q, sp_wait_d;
  slot_e             tag1_q, tag1_d;
  slot_e             tag2_q;

  logic [PAL_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_rg_q, ram_we_rg_d;
  logic              ram_we_b_q, ram_we_b_d;
  logic [PAL_DW-1:0] ram_d_q, ram_d_d;

  logic              bg_valid_q;
  logic [PAL_DW-1:0] bg_data_q;
  logic              sp_valid_q;
  logic [PAL_DW-1:0] sp_data_q;

  vball_pal_wbuf u_wbuf (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_we   (bus.cpu_we),
    .cpu_addr (bus.cpu_addr),
    .cpu_din  (bus.cpu_din),
    .drain    (slot == SLOT_CPU),
    .full     (wb_full),
    .lane_b   (wb_lane_b),
    .entry    (wb_entry),
    .data     (wb_data)
  );

  assign sp_starved = bus.sp_req && (sp_wait_q >= SpMaxWait);

  // Background is hard real-time; a starved sprite then jumps the CPU buffer.
  always_comb begin
    slot = SLOT_NONE;
    if (bus.bg_req) begin
      slot = SLOT_BG;
    end else if (sp_starved) begin
      slot = SLOT_SP;
    end else if (wb_full) begin
      slot = SLOT_CPU;
    end else if (bus.sp_req) begin
      slot = SLOT_SP;
    end
  end

  assign col_busy = bus.sp_req && (slot != SLOT_SP);

  always_comb begin
    sp_wait_d = '0;
    if (bus.sp_req && col_busy) begin
      sp_wait_d = sat_inc(sp_wait_q);
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_rg_d = 1'b0;
    ram_we_b_d  = 1'b0;
    ram_d_d     = ram_d_q;
    tag1_d      = SLOT_NONE;
    unique case (slot)
      SLOT_BG: begin
        ram_addr_d = bus.bg_addr;
        tag1_d     = SLOT_BG;
      end
      SLOT_SP: begin
        ram_addr_d = bus.sp_addr;
        tag1_d     = SLOT_SP;
      end
      SLOT_CPU: begin
        ram_addr_d = wb_entry;
        if (wb_lane_b) begin
          ram_we_b_d = 1'b1;
          ram_d_d    = {8'h00, wb_data[3:0]};
        end else begin
          ram_we_rg_d = 1'b1;
          ram_d_d     = {wb_data, 4'h0};
        end
      end
      SLOT_NONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sp_wait_q   <= '0;
      tag1_q      <= SLOT_NONE;
      tag2_q      <= SLOT_NONE;
      ram_addr_q  <= '0;
      ram_we_rg_q <= 1'b0;
      ram_we_b_q  <= 1'b0;
      ram_d_q     <= '0;
    end else begin
      sp_wait_q   <= sp_wait_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      ram_addr_q  <= ram_addr_d;
      ram_we_rg_q <= ram_we_rg_d;
      ram_we_b_q  <= ram_we_b_d;
      ram_d_q     <= ram_d_d;
    end
  end

  // ram_q now belongs to the read issued two edges ago; route it by its tag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bg_valid_q <= 1'b0;
      bg_data_q  <= '0;
      sp_valid_q <= 1'b0;
      sp_data_q  <= '0;
    end else begin
      bg_valid_q <= (tag2_q == SLOT_BG);
      sp_valid_q <= (tag2_q == SLOT_SP);
      if (tag2_q == SLOT_BG) begin
        bg_data_q <= bus.ram_q;
      end
      if (tag2_q == SLOT_SP) begin
        sp_data_q <= bus.ram_q;
      end
    end
  end

  assign bus.col_busy  = col_busy;
  assign bus.cpu_busy  = wb_full;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we_rg = ram_we_rg_q;
  assign bus.ram_we_b  = ram_we_b_q;
  assign bus.ram_d     = ram_d_q;
  assign bus.bg_valid  = bg_valid_q;
  assign bus.bg_data   = bg_data_q;
  assign bus.sp_valid  = sp_valid_q;
  assign bus.sp_data   = sp_data_q;

endmodule

// File: tb/tb_vball_pal_arbiter.sv
// Directed bench for vball_pal_arbiter with a write-first palette RAM model.
module tb_vball_pal_arbiter;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic        pl_we   = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [11:0] pl_data = '0;
  logic [11:0] mem [1024];

  vball_pal_arbiter_if bus ();

  vball_pal_arbiter #(.SP_MAXWAIT(6)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous write-first RAM with per-lane enables.
  always @(posedge clk_sys) begin
    logic [11:0] w;
    if (pl_we) mem[pl_addr] = pl_data;
    w = mem[bus.ram_addr];
    if (bus.ram_we_rg) w[11:4] = bus.ram_d[11:4];
    if (bus.ram_we_b)  w[3:0]  = bus.ram_d[3:0];
    mem[bus.ram_addr] = w;
    if (bus.ram_we_rg || bus.ram_we_b) wr_count = wr_count + 1;
    bus.ram_q <= w;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [11:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wr0;
    int          waits;
    logic        granted;
    logic [11:0] tmp;

    bus.bg_req = 0; bus.bg_addr = '0; bus.sp_req = 0; bus.sp_addr = '0;
    bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;

    preload(10'h155, 12'hABC);
    preload(10'h2AA, 12'h123);
    preload(10'h050, 12'h9C3);
    preload(10'h021, 12'h000);
    preload(10'h020, 12'h000);
    preload(10'h012, 12'h000);
    reset = 0;
    step();

    // Reset in the middle of a background read.
    bus.bg_req = 1; bus.bg_addr = 10'h155;
    step();
    bus.bg_req = 0;
    reset = 1;
    step();
    step();
    check_val("rst_bg_valid_a", 32'(bus.bg_valid), 32'h0);
    check_val("rst_sp_valid", 32'(bus.sp_valid), 32'h0);
    step();
    check_val("rst_bg_valid_b", 32'(bus.bg_valid), 32'h0);
    reset = 0;
    step();
    check_val("rst_cpu_busy", 32'(bus.cpu_busy), 32'h0);
    check_val("rst_col_busy", 32'(bus.col_busy), 32'(bus.sp_req));
    check_val("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check_val("rst_ram_we", 32'({bus.ram_we_rg, bus.ram_we_b}), 32'h0);
    check_val("rst_ram_d", 32'(bus.ram_d), 32'h0);

    // Background latency.
    bus.bg_req = 1; bus.bg_addr = 10'h155;
    step();
    bus.bg_req = 0;
    check_val("bg_ram_addr", 32'(bus.ram_addr), 32'h155);
    check_val("bg_valid_n0", 32'(bus.bg_valid), 32'h0);
    step();
    check_val("bg_valid_n1", 32'(bus.bg_valid), 32'h0);
    step();
    check_val("bg_valid_n2", 32'(bus.bg_valid), 32'h1);
    check_val("bg_data", 32'(bus.bg_data), 32'hABC);
    step();
    check_val("bg_valid_n3", 32'(bus.bg_valid), 32'h0);

    // Byte lanes.
    bus.cpu_we = 1; bus.cpu_addr = 11'h012; bus.cpu_din = 8'h5A;
    step();
    bus.cpu_we = 0;
    check_val("rg_busy", 32'(bus.cpu_busy), 32'h1);
    step();
    check_val("rg_we", 32'(bus.ram_we_rg), 32'h1);
    check_val("rg_we_b", 32'(bus.ram_we_b), 32'h0);
    check_val("rg_addr", 32'(bus.ram_addr), 32'h012);
    check_val("rg_data", 32'(bus.ram_d[11:4]), 32'h5A);
    check_val("rg_busy_clr", 32'(bus.cpu_busy), 32'h0);
    bus.cpu_we = 1; bus.cpu_addr = 11'h412; bus.cpu_din = 8'h07;
    step();
    bus.cpu_we = 0;
    step();
    check_val("b_we", 32'(bus.ram_we_b), 32'h1);
    check_val("b_we_rg", 32'(bus.ram_we_rg), 32'h0);
    check_val("b_addr", 32'(bus.ram_addr), 32'h012);
    check_val("b_data", 32'(bus.ram_d[3:0]), 32'h7);
    bus.sp_req = 1; bus.sp_addr = 10'h012;
    #1;
    check_val("lane_sp_col_busy", 32'(bus.col_busy), 32'h0);
    step();
    bus.sp_req = 0;
    step();
    step();
    check_val("lane_sp_valid", 32'(bus.sp_valid), 32'h1);
    check_val("lane_sp_data", 32'(bus.sp_data), 32'h5A7);

    // Busy / drop.
    wr0 = wr_count;
    bus.bg_req = 1; bus.bg_addr = 10'h100;
    bus.cpu_we = 1; bus.cpu_addr = 11'h020; bus.cpu_din = 8'h11;
    step();
    bus.bg_req = 0;
    bus.cpu_we = 1; bus.cpu_addr = 11'h021; bus.cpu_din = 8'h22;
    check_val("drop_busy", 32'(bus.cpu_busy), 32'h1);
    step();
    bus.cpu_we = 0;
    for (int i = 0; i < 4; i++) begin
      bus.bg_req = (i % 2 == 0);
      step();
    end
    bus.bg_req = 0;
    step();
    check_val("drop_wr_count", 32'(wr_count - wr0), 32'h1);
    tmp = mem[10'h020];
    check_val("drop_first_data", 32'(tmp[11:4]), 32'h11);
    tmp = mem[10'h021];
    check_val("drop_second_absent", 32'(tmp), 32'h0);

    // Sprite starvation bound.
    waits = 0;
    granted = 1'b0;
    bus.bg_addr = 10'h100; bus.sp_addr = 10'h2AA;
    bus.cpu_addr = 11'h300; bus.cpu_din = 8'h44;
    for (int i = 0; i < 40 && !granted; i++) begin
      bus.bg_req = (i % 2 == 0);
      bus.cpu_we = !bus.cpu_busy;
      bus.sp_req = 1;
      #1;
      if (!bus.col_busy) begin
        granted = 1'b1;
      end else begin
        waits++;
        @(posedge clk_sys);
        #1;
      end
    end
    check_val("starve_granted", 32'(granted), 32'h1);
    check_val("starve_waits", 32'(waits), 32'd7);
    step();
    bus.sp_req = 0; bus.bg_req = 0; bus.cpu_we = 0;
    check_val("starve_ram_addr", 32'(bus.ram_addr), 32'h2AA);
    step();
    step();
    check_val("starve_sp_valid", 32'(bus.sp_valid), 32'h1);
    check_val("starve_sp_data", 32'(bus.sp_data), 32'h123);

    // Collision of all three requesters.
    bus.cpu_we = 1; bus.cpu_addr = 11'h040; bus.cpu_din = 8'h33;
    step();
    bus.cpu_we = 0;
    bus.bg_req = 1; bus.bg_addr = 10'h101;
    bus.sp_req = 1; bus.sp_addr = 10'h050;
    #1;
    check_val("coll_col_busy0", 32'(bus.col_busy), 32'h1);
    step();
    bus.bg_req = 0;
    check_val("coll_bg_addr", 32'(bus.ram_addr), 32'h101);
    #1;
    check_val("coll_col_busy1", 32'(bus.col_busy), 32'h1);
    step();
    check_val("coll_cpu_we", 32'(bus.ram_we_rg), 32'h1);
    check_val("coll_cpu_addr", 32'(bus.ram_addr), 32'h040);
    check_val("coll_col_busy2", 32'(bus.col_busy), 32'h0);
    step();
    bus.sp_req = 0;
    check_val("coll_sp_addr", 32'(bus.ram_addr), 32'h050);
    check_val("coll_sp_we", 32'(bus.ram_we_rg), 32'h0);
    step();
    step();
    check_val("coll_sp_valid", 32'(bus.sp_valid), 32'h1);
    check_val("coll_sp_data", 32'(bus.sp_data), 32'h9C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vball_pal_arbiter.md
# vball_pal_arbiter

Arbiter and sequencer for the single-port 1024×12 palette RAM. Three requesters share it: background pixel lookups (hard real-time), sprite renderer lookups (stallable, `col_busy` handshake), and CPU palette writes (posted, byte-lane). The block sits between the video engines/CPU bus and the palette RAM. It guarantees a fixed background lookup latency and bounded sprite wait.

## Interface
Parameters:
- `SP_MAXWAIT`, default 6: sprite wait cycles after which the sprite outranks a pending CPU write.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `bg_req` in 1: background lookup strobe; at most one every 2 cycles.
- `bg_addr` in 10: background palette index.
- `bg_valid` out 1: one-cycle pulse when `bg_data` is valid.
- `bg_data` out 12: {R,G,B} for the background.
- `sp_req` in 1: sprite lookup request; held until granted.
- `sp_addr` in 10: sprite palette index; held with `sp_req`.
- `col_busy` out 1: 1 = sprite request not granted this cycle.
- `sp_valid` out 1: one-cycle pulse when `sp_data` is valid.
- `sp_data` out 12: sprite color.
- `cpu_we` in 1: CPU write strobe, single cycle.
- `cpu_addr` in 11: bit 10 selects the lane (0 = R/G byte, 1 = B nibble); bits 9:0 are the entry.
- `cpu_din` in 8: write data. The R/G lane is {R[3:0],G[3:0]}; the B lane uses [3:0].
- `cpu_busy` out 1: write buffer full; a `cpu_we` while high is dropped.
- `ram_addr` out 10: RAM address, registered.
- `ram_we_rg` out 1: RAM write enable for bits 11:4, registered.
- `ram_we_b` out 1: RAM write enable for bits 3:0, registered.
- `ram_d` out 12: RAM write data, registered.
- `ram_q` in 12: RAM read data, valid one cycle after `ram_addr`.

## Operation
- **Write buffer:** one entry: {lane, entry, data}, plus a `full` flag.
  - A `cpu_we` while the buffer is empty loads it and sets `full`.
  - `cpu_busy` = `full`.
  - A `cpu_we` in the same cycle the buffer drains is dropped, because `cpu_busy` was still high.
- **Slot arbitration:** one RAM slot per cycle. Priority, evaluated at each edge:
  1. `bg_req`.
  2. The sprite, if `sp_wait` ≥ `SP_MAXWAIT`.
  3. The CPU buffer.
  4. `sp_req`.
  5. Idle.
- **Sprite grant:**
  - `col_busy` = `sp_req` AND NOT (sprite wins this cycle); combinational from the current requests and state.
  - The sprite engine advances on `sp_req & !col_busy`.
- **Wait counter:** `sp_wait` (4 bits) increments on each cycle with `sp_req & col_busy`, saturating at 15. It clears on grant or when `sp_req` is low.
- **Idle slot:** `ram_we_*` = 0; `ram_addr` holds its last value.
- **CPU slot:**
  - `ram_addr` = the buffered entry.
  - R/G lane: `ram_d[11:4]` = data and `ram_we_rg` = 1.
  - B lane: `ram_d[3:0]` = data[3:0] and `ram_we_b` = 1.
  - `full` clears at the same edge.
- **Read tags:** a 2-stage tag pipeline {none, bg, sp} follows each read slot. Stage 2 routes `ram_q` into `bg_data` or `sp_data` and pulses the matching valid.
- **Reset:** all outputs are 0, `full` = 0, `sp_wait` = 0, tags = none. A transaction in flight at reset is discarded, with no valid pulse.

## Timing
- A request sampled at edge N drives `ram_*` from edge N. `ram_q` is valid in cycle N+1. `bg_data`/`sp_data` and their valid are registered at edge N+2, which is a fixed 2-cycle latency for both read ports.
- Background reads are never delayed. A `bg_req` 2 cycles apart always fits.
- A CPU write is issued within 2 cycles of acceptance unless a starved sprite holds the slot. Worst case is 2 + `SP_MAXWAIT`-bounded.
- Sprite worst-case wait when the background uses every other cycle and the CPU writes continuously: `SP_MAXWAIT` + 1 cycles.
- Write-then-read of the same entry in consecutive slots returns the new value. This relies on the RAM being write-first. The block does no forwarding.

## Structure
- A shared package holds:
  - the slot tag enum (`SLOT_NONE`, `SLOT_BG`, `SLOT_SP`, `SLOT_CPU`);
  - the lane select constant (`LANE_B` = `cpu_addr` bit 10);
  - the palette widths (`PAL_AW` = 10, `PAL_DW` = 12).
- Natural sub-module: `vball_pal_wbuf`, the one-entry CPU posted-write buffer with `full`/drain handshake.
- Arbitration and the tag pipeline stay in the top module.

## Test plan
- **Reset:** assert `reset` mid-read → `bg_valid`/`sp_valid` stay 0. After release, `cpu_busy` = 0, `col_busy` = `sp_req`, and all RAM outputs are 0.
- **Background latency:** `bg_req` with `bg_addr` = 0x155 at edge N, RAM model preloaded with 0xABC → `bg_valid` = 1 and `bg_data` = 0xABC exactly at edge N+2.
- **Byte lanes:**
  - write `cpu_addr` = 0x012, `cpu_din` = 0x5A → `ram_we_rg` = 1 and `ram_d[11:4]` = 0x5A at `ram_addr` 0x012;
  - write `cpu_addr` = 0x412, `cpu_din` = 0x07 → `ram_we_b` = 1 and `ram_d[3:0]` = 7;
  - a subsequent sprite read of 0x012 returns 0x5A7.
- **Busy/drop:** two `cpu_we` on consecutive cycles while `bg_req` is held every other cycle → the second is dropped (`cpu_busy` = 1 that cycle) and exactly one write reaches the RAM.
- **Sprite starvation bound:** `bg_req` every 2nd cycle, CPU refilling the buffer whenever `cpu_busy` = 0, `sp_req` held → the sprite is granted within `SP_MAXWAIT` + 1 = 7 cycles. `sp_data` follows 2 cycles after the grant.
- **Collision:** `bg_req`, `sp_req` and a full buffer in the same cycle → `bg` served, `col_busy` = 1, CPU write issued on the next cycle, sprite on the one after.
